// File: rtl/tm_lif_if.sv
// tm_lif_if: control, input-current and result bundle for the time-multiplexed LIF array
interface tm_lif_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int IDXW      = 2
);
  logic                       en;
  logic [WIDTH-1:0]           threshold;
  logic [WIDTH-1:0]           syn_weight;
  logic [N_NEURONS*WIDTH-1:0] current_in;
  logic [N_NEURONS-1:0]       spikes;
  logic [WIDTH-1:0]           state_out;
  logic [IDXW-1:0]            state_idx;
  logic                       state_valid;
  logic                       frame_done;
  modport master (
    output en, threshold, syn_weight, current_in,
    input  spikes, state_out, state_idx, state_valid, frame_done
  );
  modport slave (
    input  en, threshold, syn_weight, current_in,
    output spikes, state_out, state_idx, state_valid, frame_done
  );
endinterface

// File: rtl/tm_lif_array.sv
// tm_lif_array: round-robin array of leaky integrate-and-fire neurons sharing one update datapath
module tm_lif_array #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int CHAIN      = 1
) (
  input logic    clk,
  input logic    rst,
  tm_lif_if.slave bus
);
  localparam int IDXW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
  localparam int RW   = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
  logic [WIDTH-1:0]     v_q [N_NEURONS];
  logic [WIDTH-1:0]     v_d [N_NEURONS];
  logic [RW-1:0]        r_q [N_NEURONS];
  logic [RW-1:0]        r_d [N_NEURONS];
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic [IDXW-1:0]      idx_q, idx_d, oidx_q, oidx_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 valid_q, valid_d, done_q, done_d;
  logic [WIDTH-1:0]     v_sel, c_sel, sat, v_new;
  logic [RW-1:0]        r_sel;
  logic [WIDTH+1:0]     sum;
  logic                 syn_on, refr, fire;
  always_comb begin
    v_sel  = '0;
    r_sel  = '0;
    c_sel  = '0;
    syn_on = 1'b0;
    for (int i = 0; i < N_NEURONS; i++)
      if (idx_q == IDXW'(i)) begin
        v_sel  = v_q[i];
        r_sel  = r_q[i];
        c_sel  = bus.current_in[i*WIDTH +: WIDTH];
        syn_on = CHAIN != 0 && i > 0 && spikes_q[i == 0 ? 0 : i - 1];
      end
    sum   = {2'b0, v_sel - (v_sel >> LEAK_SHIFT)} + {2'b0, c_sel} + (syn_on ? {2'b0, bus.syn_weight} : '0);
    sat   = |sum[WIDTH+1:WIDTH] ? '1 : sum[WIDTH-1:0];
    refr  = r_sel != '0;
    fire  = !refr && bus.threshold != '0 && sum >= {2'b0, bus.threshold};
    v_new = (refr || fire) ? '0 : sat;
    v_d      = v_q;
    r_d      = r_q;
    spikes_d = spikes_q;
    idx_d    = idx_q;
    out_d    = out_q;
    oidx_d   = oidx_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (bus.en) begin
      for (int i = 0; i < N_NEURONS; i++)
        if (idx_q == IDXW'(i)) begin
          v_d[i]      = v_new;
          r_d[i]      = refr ? r_sel - 1'b1 : fire ? RW'(REFRAC) : '0;
          spikes_d[i] = fire;
        end
      idx_d   = idx_q == IDXW'(N_NEURONS - 1) ? '0 : idx_q + 1'b1;
      out_d   = v_new;
      oidx_d  = idx_q;
      valid_d = 1'b1;
      done_d  = idx_q == IDXW'(N_NEURONS - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      spikes_q <= '0;
      idx_q    <= '0;
      out_q    <= '0;
      oidx_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      v_q      <= v_d;
      r_q      <= r_d;
      spikes_q <= spikes_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      oidx_q   <= oidx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end
  assign bus.spikes      = spikes_q;
  assign bus.state_out   = out_q;
  assign bus.state_idx   = oidx_q;
  assign bus.state_valid = valid_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_tm_lif_array.sv
// tb_tm_lif_array: randomized and directed scoreboard bench for tm_lif_array against an arithmetic model
module tb_tm_lif_array;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tm_lif_if #(.N_NEURONS(N), .WIDTH(W), .IDXW(2)) bus ();
  tm_lif_array #(.N_NEURONS(N), .WIDTH(W), .LEAK_SHIFT(1), .REFRAC(2), .CHAIN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {int idx; int state; logic [N-1:0] spk; bit done;} exp_t;
  exp_t sb[$];
  int   obs0[$];
  bit   rec0 = 0;
  int   n_tests = 0, n_fail = 0;
  int   pot[N], rf[N], cur[N], last_state;
  logic [N-1:0] spk;
  int   midx, thr, syn;
  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin pot[i] = 0; rf[i] = 0; end
    spk = '0; midx = 0; last_state = 0;
  endtask
  task automatic model_update();
    int i, s;
    i = midx;
    if (rf[i] > 0) begin
      rf[i]--; pot[i] = 0; spk[i] = 1'b0;
    end else begin
      s = pot[i] - pot[i] / 2 + cur[i] + ((i > 0 && spk[i-1]) ? syn : 0);
      if (thr != 0 && s >= thr) begin
        pot[i] = 0; spk[i] = 1'b1; rf[i] = 2;
      end else begin
        pot[i] = s > 255 ? 255 : s; spk[i] = 1'b0;
      end
    end
    last_state = pot[i];
    sb.push_back('{i, pot[i], spk, i == N - 1});
    midx = (midx + 1) % N;
  endtask
  task automatic cyc(input logic r, input logic e);
    @(negedge clk);
    #1;
    rst = r;
    bus.en = e;
    bus.threshold = W'(thr);
    bus.syn_weight = W'(syn);
    for (int i = 0; i < N; i++) bus.current_in[i*W +: W] = W'(cur[i]);
    if (r) model_reset();
    else if (e) model_update();
  endtask
  task automatic set_in(input int c0, input int c1, input int c2, input int c3, input int t, input int s);
    cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3; thr = t; syn = s;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.state_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("state_idx", int'(bus.state_idx), e.idx);
        chk("state_out", int'(bus.state_out), e.state);
        chk("spikes", int'(bus.spikes), int'(e.spk));
        chk("frame_done", int'(bus.frame_done), int'(e.done));
        if (rec0 && bus.state_idx == 0) obs0.push_back(int'(bus.state_out));
      end
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
      chk("missing_valid", 0, 1);
    end
    if (bus.frame_done && !bus.state_valid) chk("done_without_valid", 1, 0);
  end
  initial begin
    int exp0[6] = '{32'h20, 32'h30, 0, 0, 0, 32'h20};
    int hold_idx;
    model_reset();
    set_in($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255), 5, 7);
    bus.en = 1'b1;
    cyc(1, 1);
    cyc(1, 1);
    @(posedge clk); #1;
    chk("rst_spikes", int'(bus.spikes), 0);
    chk("rst_state_out", int'(bus.state_out), 0);
    chk("rst_valid", int'(bus.state_valid), 0);
    // integrate, fire, refractory on neuron 0
    set_in(32'h20, 0, 0, 0, 32'h38, 0);
    rec0 = 1;
    repeat (6 * N) cyc(0, 1);
    cyc(0, 0);
    rec0 = 0;
    chk("obs0_count", obs0.size(), 6);
    for (int k = 0; k < 6 && k < obs0.size(); k++) chk($sformatf("n0_seq%0d", k), obs0[k], exp0[k]);
    // saturation with firing disabled
    cyc(1, 0);
    set_in(0, 32'hFF, 0, 0, 0, 0);
    repeat (3 * N) cyc(0, 1);
    cyc(0, 0);
    chk("sat_no_spike1", int'(bus.spikes[1]), 0);
    // chain avalanche, then with zero weight
    cyc(1, 0);
    set_in(32'hFF, 0, 0, 0, 32'h80, 32'h90);
    repeat (N) cyc(0, 1);
    cyc(0, 0);
    chk("avalanche", int'(bus.spikes), 4'hF);
    cyc(1, 0);
    set_in(32'hFF, 0, 0, 0, 32'h80, 0);
    repeat (N) cyc(0, 1);
    cyc(0, 0);
    chk("no_chain", int'(bus.spikes), 4'h1);
    // stall mid-frame
    set_in(32'h11, 32'h22, 32'h33, 32'h44, 32'h60, 32'h10);
    repeat (N + 2) cyc(0, 1);
    hold_idx = midx;
    repeat (5) begin
      cyc(0, 0);
      @(posedge clk); #1;
      chk("stall_valid", int'(bus.state_valid), 0);
      chk("stall_done", int'(bus.frame_done), 0);
      chk("stall_spikes", int'(bus.spikes), int'(spk));
      chk("stall_state", int'(bus.state_out), last_state);
    end
    chk("stall_resume_idx", midx, hold_idx);
    repeat (N) cyc(0, 1);
    // reset mid-frame at idx 2
    while (midx != 2) cyc(0, 1);
    cyc(1, 1);
    repeat (N) cyc(0, 1);
    // randomized traffic with occasional resets and stalls
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255),
             ($urandom_range(9) == 0) ? 0 : $urandom_range(255), $urandom_range(255));
      if ($urandom_range(3) == 0) for (int i = 0; i < N; i++) cur[i] = cur[i] & 32'h0F;
      cyc($urandom_range(49) == 0, $urandom_range(4) != 0);
    end
    cyc(0, 0);
    cyc(0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
